y86_instr_packer: RTL
=====================

Name: y86_instr_packer

Overview:
- Byte-serial encoder for Y86-64 instructions. It is the inverse of the fetch-stage split/align logic.
- Accepts one decoded instruction per handshake: icode, ifun, rA, rB, valC.
- Emits its encoded bytes, one per cycle, little-endian, with the byte address for each.
- Feeds the instruction-memory program loader and the self-check bench, which packs instructions and refetches them through the fetch stage.

Parameters:
- ADDR_W, 64, width of byte address and address arithmetic (modulo 2^ADDR_W).
- RESET_ADDR, 0, value of the running address after reset.

Ports:
- clock  input  1  single clock, all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  packer can accept an instruction this cycle.
- in_icode  input  4  instruction code.
- in_ifun  input  4  function code.
- in_rA  input  4  register A (RNONE=4'hF when unused).
- in_rB  input  4  register B.
- in_valC  input  64  constant word.
- in_addr_load  input  1  with accepted instruction: start at in_addr instead of running address.
- in_addr  input  ADDR_W  explicit start address.
- out_valid  output  1  out_byte/out_addr valid.
- out_ready  input  1  downstream takes byte.
- out_byte  output  8  encoded byte.
- out_addr  output  ADDR_W  byte address of out_byte.
- out_first  output  1  out_byte is byte 0 of an instruction.
- out_last  output  1  out_byte is final byte of an instruction.
- err_invalid  output  1  one-cycle pulse: accepted instruction had illegal icode.
- next_addr  output  ADDR_W  running address (address following last packed instruction).

Behaviour:
- Encoding, byte index k:
  - k=0: {icode,ifun}, icode in bits 7:4.
  - k=1, only if regids needed: {rA,rB}, rA in bits 7:4.
  - valC bytes follow, least significant byte first.
- Lengths by icode:
  - HALT(0), NOP(1), RET(9): 1 byte.
  - RRMOVQ(2), OPQ(6), PUSHQ(A), POPQ(B): 2 bytes.
  - JXX(7), CALL(8): 9 bytes, valC starting at k=1.
  - IRMOVQ(3), RMMOVQ(4), MRMOVQ(5): 10 bytes, valC starting at k=2.
- Field values (ifun, rA, rB) are not range-checked; they are emitted as given.
- FSM states IDLE and EMIT.
  - IDLE: in_ready=1, out_valid=0.
  - Accept (in_valid&in_ready), valid icode: latch fields; set byte index=0; set start address (in_addr if in_addr_load, else next_addr); go to EMIT.
  - Accept, icode C..F: no bytes emitted, err_invalid=1 next cycle, next_addr unchanged, stay IDLE.
  - EMIT: out_valid=1. On out_valid&out_ready: index+1 and out_addr+1.
  - Handshake with out_last=1: next_addr<=out_addr+1; go to IDLE.
- Back-to-back: in_ready also =1 in EMIT when out_last&out_ready (combinational path out_ready->in_ready permitted).
  - A new instruction accepted in that cycle enters EMIT directly, with no idle bubble.
  - With in_addr_load=0, its first byte address equals the just-completed instruction's end address.
- Holding: out_byte, out_addr, out_first and out_last are stable while out_valid&~out_ready. Input fields are don't-care after acceptance.
- Latency: first byte valid the cycle after acceptance. One byte per cycle under continuous out_ready.
- Address arithmetic wraps modulo 2^ADDR_W, with no error flagged. An instruction may straddle the wrap.
- out_first and out_last are both 1 for 1-byte instructions.
- Reset (async, any time, including mid-instruction):
  - state=IDLE, out_valid=0, err_invalid=0, out_byte=0, out_addr=RESET_ADDR, out_first=0, out_last=0, next_addr=RESET_ADDR.
  - A partially emitted instruction is discarded; nothing resumes after reset release.

Test Plan:
- irmovq: icode=3, ifun=0, rA=F, rB=0, valC=64'h0000_0000_0000_0100, addr_load=1, addr=0x40, out_ready=1 -> bytes 30 F0 00 01 00 00 00 00 00 00 at 0x40..0x49; first on 0x40, last on 0x49; next_addr=0x4A.
- Back-to-back, out_ready=1: halt then ret, addr_load=0 from next_addr=0x10 -> bytes 00@0x10 (first&last), 90@0x11 with no gap cycle; in_ready high during 00's handshake; next_addr=0x12.
- Backpressure: call valC=0x1122334455667788 with out_ready toggling 1,0,0,1… -> outputs held during stalls; sequence 80 88 77 66 55 44 33 22 11; exactly 9 handshakes.
- Invalid icode: icode=D -> no out_valid; err_invalid single pulse; next_addr unchanged; in_ready stays 1.
- Address wrap: opq ifun=0, rA=2, rB=3 at addr=0xFFFF_FFFF_FFFF_FFFF -> 60@…FF, 23@0x0; next_addr=1.
- Reset mid-rmmovq after byte 3 -> out_valid drops asynchronously; after release: IDLE, next_addr=RESET_ADDR, no residual bytes emitted.

Source files
------------

// File: rtl/y86_instr_packer.sv
// Y86-64 instruction packer: turns one decoded instruction into its
// little-endian byte stream, one byte per cycle, each tagged with its address.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no instruction in flight; ready for a new one
// EMIT  | presenting byte idx of the latched instruction on out_*
module y86_instr_packer #(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [3:0]        in_rA,
    input  logic [3:0]        in_rB,
    input  logic [63:0]       in_valC,
    input  logic              in_addr_load,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_first,
    output logic              out_last,
    output logic              err_invalid,
    output logic [ADDR_W-1:0] next_addr
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [3:0]  icode_q;
    logic [3:0]  ifun_q;
    logic [3:0]  ra_q;
    logic [3:0]  rb_q;
    logic [63:0] valc_q;
    logic [3:0]  idx;

    // Encoded length in bytes; 0 marks an illegal icode (C..F).
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            4'h0, 4'h1, 4'h9:             len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:       len = 4'd2;
            4'h7, 4'h8:                   len = 4'd9;
            4'h3, 4'h4, 4'h5:             len = 4'd10;
            default:                      len = 4'd0;
        endcase
        return len;
    endfunction

    // Byte k of the encoding: opcode, optional register byte, then valC LSB-first.
    function automatic logic [7:0] byte_at(input logic [3:0]  icode,
                                           input logic [3:0]  ifun,
                                           input logic [3:0]  ra,
                                           input logic [3:0]  rb,
                                           input logic [63:0] valc,
                                           input logic [3:0]  k);
        logic        has_regs;
        logic [3:0]  valc_off;
        logic [3:0]  vi;
        logic [63:0] sh;
        logic [7:0]  b;
        has_regs = (icode == 4'h2) || (icode == 4'h3) || (icode == 4'h4) ||
                   (icode == 4'h5) || (icode == 4'h6) || (icode == 4'hA) ||
                   (icode == 4'hB);
        valc_off = has_regs ? 4'd2 : 4'd1;
        vi       = k - valc_off;
        sh       = valc >> {vi, 3'b000};
        if (k == 4'd0)
            b = {icode, ifun};
        else if (has_regs && (k == 4'd1))
            b = {ra, rb};
        else
            b = sh[7:0];
        return b;
    endfunction

    logic              accept;
    logic [3:0]        len_q;
    logic [3:0]        len_in;
    logic [3:0]        idx_nxt;
    logic [ADDR_W-1:0] start_base;

    assign out_valid  = (state == EMIT);
    // Ready in the final handshake so a following instruction needs no bubble.
    assign in_ready   = (state == IDLE) || (out_last && out_ready);
    assign accept     = in_valid && in_ready;
    assign len_q      = instr_len(icode_q);
    assign len_in     = instr_len(in_icode);
    assign idx_nxt    = idx + 4'd1;
    // next_addr is not yet updated during the final handshake, so chain from out_addr.
    assign start_base = (state == EMIT) ? out_addr + ADDR_W'(1) : next_addr;

    // FSM, byte index, registered outputs and running address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            icode_q     <= 4'h0;
            ifun_q      <= 4'h0;
            ra_q        <= 4'h0;
            rb_q        <= 4'h0;
            valc_q      <= 64'h0;
            idx         <= 4'd0;
            out_byte    <= 8'h00;
            out_addr    <= RESET_ADDR;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            err_invalid <= 1'b0;
            next_addr   <= RESET_ADDR;
        end else begin
            err_invalid <= 1'b0;

            if ((state == EMIT) && out_ready) begin
                if (out_last) begin
                    next_addr <= out_addr + ADDR_W'(1);
                    state     <= IDLE;
                    out_first <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    idx       <= idx_nxt;
                    out_addr  <= out_addr + ADDR_W'(1);
                    out_byte  <= byte_at(icode_q, ifun_q, ra_q, rb_q, valc_q, idx_nxt);
                    out_first <= 1'b0;
                    out_last  <= (idx_nxt == len_q - 4'd1);
                end
            end

            if (accept) begin
                if (len_in != 4'd0) begin
                    icode_q   <= in_icode;
                    ifun_q    <= in_ifun;
                    ra_q      <= in_rA;
                    rb_q      <= in_rB;
                    valc_q    <= in_valC;
                    idx       <= 4'd0;
                    out_addr  <= in_addr_load ? in_addr : start_base;
                    out_byte  <= {in_icode, in_ifun};
                    out_first <= 1'b1;
                    out_last  <= (len_in == 4'd1);
                    state     <= EMIT;
                end else begin
                    err_invalid <= 1'b1;
                end
            end
        end
    end

endmodule
